// File: rtl/fault_monitor_seq_if.sv
// Raw-sample handshake bundle feeding fault_monitor_seq (valid/ready plus the three sensor channels).
interface fault_monitor_seq_if;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] current_in;
  logic [15:0] vibration_in;
  logic [15:0] temperature_in;

  modport master (
    output sample_valid,
    output current_in,
    output vibration_in,
    output temperature_in,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  current_in,
    input  vibration_in,
    input  temperature_in,
    output sample_ready
  );
endinterface

// File: rtl/fault_monitor_seq.sv
// Window-averaging sequencer and fault debouncer in front of the combinational fault classifier.
// Optional macro FAULT_MON_FAST_TRIP_EN: classifier code 3'b100 trips on the first window it appears.
module fault_monitor_seq #(
  parameter int unsigned WIN_LOG2 = 3,
  parameter int unsigned CONFIRM  = 3
) (
  input  logic                clk,
  input  logic                rst,
  fault_monitor_seq_if.slave  smp,
  output logic [15:0]         avg_current,
  output logic [15:0]         avg_vibration,
  output logic [15:0]         avg_temperature,
  input  logic [2:0]          class_fault,
  output logic [2:0]          last_class,
  output logic                eval_strobe,
  output logic                trip,
  output logic [2:0]          fault_code,
  input  logic                trip_ack
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SUM_W   = DATA_W + WIN_LOG2;
  localparam int unsigned CNT_W   = WIN_LOG2;
  localparam int unsigned MATCH_W = $clog2(CONFIRM + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST  = {CNT_W{1'b1}};
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(CONFIRM);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_EVAL    = 2'd1;
  localparam logic [1:0] ST_TRIPPED = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [SUM_W-1:0]   sum_cur_q, sum_cur_d;
  logic [SUM_W-1:0]   sum_vib_q, sum_vib_d;
  logic [SUM_W-1:0]   sum_tmp_q, sum_tmp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [2:0]         prev_q, prev_d;
  logic [DATA_W-1:0]  avg_cur_q, avg_cur_d;
  logic [DATA_W-1:0]  avg_vib_q, avg_vib_d;
  logic [DATA_W-1:0]  avg_tmp_q, avg_tmp_d;
  logic [2:0]         last_class_q, last_class_d;
  logic               eval_strobe_q, eval_strobe_d;
  logic               trip_q, trip_d;
  logic [2:0]         fault_code_q, fault_code_d;

  logic               accept;
  logic [SUM_W-1:0]   nsum_cur, nsum_vib, nsum_tmp;
  logic [MATCH_W-1:0] match_upd;
  logic               trip_now;

  // Ready is a pure state decode so no sample can slip in during EVAL or TRIPPED.
  assign smp.sample_ready = (state_q == ST_ACCUM);
  assign accept           = smp.sample_valid & smp.sample_ready;

  assign nsum_cur = sum_cur_q + SUM_W'(smp.current_in);
  assign nsum_vib = sum_vib_q + SUM_W'(smp.vibration_in);
  assign nsum_tmp = sum_tmp_q + SUM_W'(smp.temperature_in);

  // Next-state: accumulate, classify/debounce, wait for acknowledge.
  always_comb begin
    state_d       = state_q;
    sum_cur_d     = sum_cur_q;
    sum_vib_d     = sum_vib_q;
    sum_tmp_d     = sum_tmp_q;
    cnt_d         = cnt_q;
    match_d       = match_q;
    prev_d        = prev_q;
    avg_cur_d     = avg_cur_q;
    avg_vib_d     = avg_vib_q;
    avg_tmp_d     = avg_tmp_q;
    last_class_d  = last_class_q;
    eval_strobe_d = 1'b0;
    trip_d        = trip_q;
    fault_code_d  = fault_code_q;
    match_upd     = match_q;
    trip_now      = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            avg_cur_d = DATA_W'(nsum_cur >> WIN_LOG2);
            avg_vib_d = DATA_W'(nsum_vib >> WIN_LOG2);
            avg_tmp_d = DATA_W'(nsum_tmp >> WIN_LOG2);
            sum_cur_d = '0;
            sum_vib_d = '0;
            sum_tmp_d = '0;
            cnt_d     = '0;
            state_d   = ST_EVAL;
          end else begin
            sum_cur_d = nsum_cur;
            sum_vib_d = nsum_vib;
            sum_tmp_d = nsum_tmp;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_EVAL: begin
        last_class_d  = class_fault;
        eval_strobe_d = 1'b1;
        // A repeat of the previous non-zero code extends the run; anything else restarts it.
        if ((class_fault != 3'b000) && (class_fault == prev_q)) begin
          match_upd = (match_q == MATCH_MAX) ? match_q : match_q + MATCH_W'(1);
        end else begin
          match_upd = (class_fault != 3'b000) ? MATCH_W'(1) : '0;
        end
        match_d  = match_upd;
        prev_d   = class_fault;
        trip_now = (match_upd == MATCH_MAX);
`ifdef FAULT_MON_FAST_TRIP_EN
        if (class_fault == 3'b100) begin
          trip_now = 1'b1;
        end
`else
`endif
        if (trip_now) begin
          trip_d       = 1'b1;
          fault_code_d = class_fault;
          state_d      = ST_TRIPPED;
        end else begin
          state_d      = ST_ACCUM;
        end
      end

      ST_TRIPPED: begin
        if (trip_ack) begin
          trip_d       = 1'b0;
          fault_code_d = 3'b000;
          match_d      = '0;
          prev_d       = 3'b000;
          state_d      = ST_ACCUM;
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ACCUM;
      sum_cur_q     <= '0;
      sum_vib_q     <= '0;
      sum_tmp_q     <= '0;
      cnt_q         <= '0;
      match_q       <= '0;
      prev_q        <= 3'b000;
      avg_cur_q     <= '0;
      avg_vib_q     <= '0;
      avg_tmp_q     <= '0;
      last_class_q  <= 3'b000;
      eval_strobe_q <= 1'b0;
      trip_q        <= 1'b0;
      fault_code_q  <= 3'b000;
    end else begin
      state_q       <= state_d;
      sum_cur_q     <= sum_cur_d;
      sum_vib_q     <= sum_vib_d;
      sum_tmp_q     <= sum_tmp_d;
      cnt_q         <= cnt_d;
      match_q       <= match_d;
      prev_q        <= prev_d;
      avg_cur_q     <= avg_cur_d;
      avg_vib_q     <= avg_vib_d;
      avg_tmp_q     <= avg_tmp_d;
      last_class_q  <= last_class_d;
      eval_strobe_q <= eval_strobe_d;
      trip_q        <= trip_d;
      fault_code_q  <= fault_code_d;
    end
  end

  assign avg_current     = avg_cur_q;
  assign avg_vibration   = avg_vib_q;
  assign avg_temperature = avg_tmp_q;
  assign last_class      = last_class_q;
  assign eval_strobe     = eval_strobe_q;
  assign trip            = trip_q;
  assign fault_code      = fault_code_q;

endmodule

// File: tb/tb_fault_monitor_seq.sv
// Scoreboard bench for fault_monitor_seq: random windows against a window-mean / run-history model.
module tb_fault_monitor_seq;

  localparam int unsigned WIN_LOG2 = 3;
  localparam int unsigned CONFIRM  = 3;
  localparam int unsigned WIN      = 1 << WIN_LOG2;

  logic        clk = 1'b0;
  logic        rst;
  logic        trip_ack;
  logic [2:0]  stub_class;
  logic [15:0] avg_current, avg_vibration, avg_temperature;
  logic [2:0]  last_class, fault_code;
  logic        eval_strobe, trip;

  fault_monitor_seq_if bus ();

  fault_monitor_seq #(.WIN_LOG2(WIN_LOG2), .CONFIRM(CONFIRM)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .smp             (bus),
    .avg_current     (avg_current),
    .avg_vibration   (avg_vibration),
    .avg_temperature (avg_temperature),
    .class_fault     (stub_class),
    .last_class      (last_class),
    .eval_strobe     (eval_strobe),
    .trip            (trip),
    .fault_code      (fault_code),
    .trip_ack        (trip_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] c;
    logic [15:0] v;
    logic [15:0] t;
    logic [2:0]  cls;
    logic        trp;
    logic [2:0]  code;
  } exp_t;

  exp_t        sb[$];
  logic [2:0]  hist[$];
  logic [15:0] win_c[WIN];
  logic [15:0] win_v[WIN];
  logic [15:0] win_t[WIN];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_random(input int mode);
    for (int i = 0; i < int'(WIN); i++) begin
      win_c[i] = (mode == 1) ? 16'hFFFF : 16'($urandom());
      win_v[i] = (mode == 1) ? 16'hFFFF : 16'($urandom_range(0, 1000));
      win_t[i] = 16'($urandom());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    trip_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hist.delete();
    sb.delete();
    chk("rst_trip", 32'(trip), 0);
    chk("rst_fault_code", 32'(fault_code), 0);
    chk("rst_avg_current", 32'(avg_current), 0);
    chk("rst_avg_vibration", 32'(avg_vibration), 0);
    chk("rst_avg_temperature", 32'(avg_temperature), 0);
    chk("rst_ready", 32'(bus.sample_ready), 1);
    chk("rst_last_class", 32'(last_class), 0);
    chk("rst_eval_strobe", 32'(eval_strobe), 0);
  endtask

  // Offer samples with random gaps until n have been taken by the handshake.
  task automatic feed(input int n);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n) begin
      @(negedge clk);
      bus.sample_valid   = ($urandom_range(0, 3) != 0);
      bus.current_in     = win_c[i];
      bus.vibration_in   = win_v[i];
      bus.temperature_in = win_t[i];
      if (bus.sample_valid && bus.sample_ready) i++;
      guard++;
      if (guard > 500) begin
        n_vec++;
        n_err++;
        $display("FAIL feed_timeout: accepted %0d of %0d samples", i, n);
        return;
      end
    end
  endtask

  task automatic run_window(input logic [2:0] cls);
    exp_t e;
    int   sc, sv, st;
    logic tr;
    stub_class = cls;
    sc = 0; sv = 0; st = 0;
    for (int i = 0; i < int'(WIN); i++) begin
      sc += int'(win_c[i]);
      sv += int'(win_v[i]);
      st += int'(win_t[i]);
    end
    e.c = 16'(sc / int'(WIN));
    e.v = 16'(sv / int'(WIN));
    e.t = 16'(st / int'(WIN));
    // Trip when the last CONFIRM classifications since the last clear are one non-zero code.
    hist.push_back(cls);
    tr = 1'b0;
    if (hist.size() >= int'(CONFIRM)) begin
      tr = (cls != 3'b000);
      for (int k = 1; k <= int'(CONFIRM); k++)
        if (hist[hist.size() - k] != cls) tr = 1'b0;
    end
`ifdef FAULT_MON_FAST_TRIP_EN
    if (cls == 3'b100) tr = 1'b1;
`endif
    e.cls  = cls;
    e.trp  = tr;
    e.code = tr ? cls : 3'b000;
    sb.push_back(e);

    feed(WIN);
    @(negedge clk);
    chk("eval_ready", 32'(bus.sample_ready), 0);
    chk("eval_avg_current", 32'(avg_current), 32'(e.c));
    chk("eval_strobe_early", 32'(eval_strobe), 0);
    bus.sample_valid = 1'b1;
    bus.current_in   = 16'($urandom());
    @(negedge clk);
    bus.sample_valid = 1'b0;
    if (tr) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.sample_valid = 1'($urandom_range(0, 1));
        chk("tripped_ready", 32'(bus.sample_ready), 0);
        chk("tripped_hold", 32'(trip), 1);
      end
      bus.sample_valid = 1'b0;
      trip_ack = 1'b1;
      @(negedge clk);
      trip_ack = 1'b0;
      chk("ack_trip", 32'(trip), 0);
      chk("ack_fault_code", 32'(fault_code), 0);
      chk("ack_ready", 32'(bus.sample_ready), 1);
      hist.delete();
    end else if ($urandom_range(0, 3) == 0) begin
      trip_ack = 1'b1;
      @(negedge clk);
      trip_ack = 1'b0;
      chk("stray_ack_trip", 32'(trip), 0);
      chk("stray_ack_ready", 32'(bus.sample_ready), 1);
    end
  endtask

  // Monitor: every eval_strobe must match the oldest outstanding window expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && eval_strobe) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: last_class %0h with empty scoreboard", last_class);
        end else begin
          e = sb.pop_front();
          chk("sb_last_class", 32'(last_class), 32'(e.cls));
          chk("sb_avg_current", 32'(avg_current), 32'(e.c));
          chk("sb_avg_vibration", 32'(avg_vibration), 32'(e.v));
          chk("sb_avg_temperature", 32'(avg_temperature), 32'(e.t));
          chk("sb_trip", 32'(trip), 32'(e.trp));
          chk("sb_fault_code", 32'(fault_code), 32'(e.code));
        end
      end
    end
  end

  initial begin
    logic [2:0] sticky;
    int         guard;
    rst = 1'b1;
    trip_ack = 1'b0;
    stub_class = 3'b000;
    bus.sample_valid = 1'b0;
    bus.current_in = '0;
    bus.vibration_in = '0;
    bus.temperature_in = '0;
    do_reset();

    for (int i = 0; i < int'(WIN); i++) begin
      win_c[i] = 16'd100; win_v[i] = 16'd20; win_t[i] = 16'd40;
    end
    run_window(3'b000);

    fill_random(0);
    for (int i = 0; i < int'(WIN); i++) win_c[i] = 16'(i);
    run_window(3'b000);

    fill_random(1);
    run_window(3'b011);
    fill_random(0);
    run_window(3'b011);
    run_window(3'b011);

    foreach (win_c[i]) win_c[i] = 16'($urandom());
    run_window(3'b011);
    run_window(3'b011);
    run_window(3'b000);
    run_window(3'b011);
    run_window(3'b011);
    run_window(3'b001);
    run_window(3'b010);
    run_window(3'b001);

    fill_random(0);
    feed(5);
    do_reset();
    for (int i = 0; i < int'(WIN); i++) begin
      win_c[i] = 16'd50; win_v[i] = 16'd50; win_t[i] = 16'd50;
    end
    run_window(3'b100);
    run_window(3'b100);
    run_window(3'b100);

    sticky = 3'b010;
    for (int w = 0; w < 40; w++) begin
      fill_random(($urandom_range(0, 7) == 0) ? 1 : 0);
      if ($urandom_range(0, 9) < 6) begin
        run_window(sticky);
      end else begin
        sticky = 3'($urandom_range(0, 7));
        run_window(sticky);
      end
    end

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
